// File: rtl/t0_bus_decoder.sv
// Receiver-side T0 address-bus decoder with a saturating bus-line toggle counter.
// Define T0_BUSINV_EN to add bus-invert decoding and count inv_in toggles.
module t0_bus_decoder #(
    parameter int W      = 8,
    parameter int STRIDE = 1,
    parameter int CNTW   = 16
) (
    input  logic            ck,
    input  logic            rst,
    input  logic [W-1:0]    b_in,
    input  logic            inc_in,
    input  logic            inv_in,
    input  logic            valid_in,
    input  logic            cnt_clr,
    output logic [W-1:0]    a_out,
    output logic            valid_out,
    output logic            err_out,
    output logic [CNTW-1:0] tog_cnt
);

    typedef enum logic {
        NOREF = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic            have_ref;
    logic [W-1:0]    prev_addr;
    logic [W-1:0]    prev_bus;
    logic            prev_inc;
    logic [W-1:0]    addr;
    logic [W-1:0]    bus_diff;
    logic            err_new;
    logic            err_nxt;
    logic [CNTW:0]   incr;
    logic [CNTW:0]   base;
    logic [CNTW:0]   sum;
    logic [CNTW-1:0] cnt_nxt;

`ifdef T0_BUSINV_EN
    logic            prev_inv;
`else
    logic            unused_inv;
    assign unused_inv = inv_in;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge ck or posedge rst) begin
        if (rst) state <= NOREF;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (valid_in) state_nxt = TRACK;
    end

    assign have_ref = (state == TRACK);

    // ---------------- decode ----------------
    always_comb begin
        addr = b_in;
`ifdef T0_BUSINV_EN
        if (inv_in) addr = ~b_in;
`endif
        // INC overrides the bus (and any inversion) once a reference exists
        if (inc_in && have_ref) addr = prev_addr + W'(STRIDE);
    end

    // INC with no reference, or INC while the bus lines moved, is a protocol violation
    assign err_new = valid_in && inc_in && (!have_ref || (b_in != prev_bus));
    assign err_nxt = err_new | (err_out & ~cnt_clr);

    // ---------------- toggle count ----------------
    assign bus_diff = b_in ^ prev_bus;

    always_comb begin
        incr = '0;
        for (int i = 0; i < W; i++) incr = incr + (CNTW+1)'(bus_diff[i]);
        incr = incr + (CNTW+1)'(inc_in ^ prev_inc);
`ifdef T0_BUSINV_EN
        incr = incr + (CNTW+1)'(inv_in ^ prev_inv);
`endif
    end

    always_comb begin
        base    = cnt_clr ? '0 : {1'b0, tog_cnt};
        sum     = base + (valid_in ? incr : '0);
        cnt_nxt = sum[CNTW] ? '1 : sum[CNTW-1:0];
    end

    // ---------------- state and outputs ----------------
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            a_out     <= '0;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
            tog_cnt   <= '0;
            prev_addr <= '0;
            prev_bus  <= '0;
            prev_inc  <= 1'b0;
`ifdef T0_BUSINV_EN
            prev_inv  <= 1'b0;
`endif
        end else begin
            valid_out <= valid_in;
            err_out   <= err_nxt;
            tog_cnt   <= cnt_nxt;
            if (valid_in) begin
                a_out     <= addr;
                prev_addr <= addr;
                prev_bus  <= b_in;
                prev_inc  <= inc_in;
`ifdef T0_BUSINV_EN
                prev_inv  <= inv_in;
`endif
            end
        end
    end

endmodule
